// File: rtl/countdown_timer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer_ctrl_if
// Description : Control/status bundle between the game front panel logic and
//               the countdown timer controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface countdown_timer_ctrl_if;
   logic        load_en;
   logic [12:0] load_sec;
   logic        start;
   logic        pause_tgl;
   logic        abort;
   logic        sec_tick;
   logic        expired;
   logic [1:0]  state;
   logic        warn;
   logic [6:0]  minutes;
   logic [5:0]  seconds;

   // Controller side: drives commands, observes timer status
   modport master (
      output load_en, load_sec, start, pause_tgl, abort,
      input  sec_tick, expired, state, warn, minutes, seconds
   );

   // Timer side: consumes commands, drives status
   modport slave (
      input  load_en, load_sec, start, pause_tgl, abort,
      output sec_tick, expired, state, warn, minutes, seconds
   );
endinterface
`default_nettype wire

// File: rtl/countdown_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer_ctrl
// Description : 1 Hz time base with start/pause/resume/done sequencing, a
//               loadable MM:SS countdown, an expiry pulse and a low-time warn.
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer_ctrl #(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int MAX_SEC       = 5999,
   parameter int WARN_SEC      = 10
) (
   input  wire                    clk,
   input  wire                    rst_n,
   countdown_timer_ctrl_if.slave  bus
);

   localparam int                  c_PRESC_W   = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(TICKS_PER_SEC - 1);
   localparam logic [c_PRESC_W-1:0] c_PRESC_ONE = c_PRESC_W'(1);
   localparam logic [12:0]          c_MAX_SEC   = 13'(MAX_SEC);
   localparam logic [12:0]          c_WARN_SEC  = 13'(WARN_SEC);
   localparam logic [12:0]          c_SIXTY     = 13'd60;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   state_t                 r_state;
   logic [12:0]            r_remaining;
   logic [c_PRESC_W-1:0]   r_presc;
   logic [6:0]             r_minutes;
   logic [5:0]             r_seconds;

   logic                   w_tick;
   logic                   w_last;
   logic [12:0]            w_load_sat;

   // The second stroke must coincide with the terminal prescaler count, so it
   // is decoded from registers rather than delayed through another flop.
   assign w_tick     = (r_state == S_RUN) && (r_presc == c_PRESC_MAX);
   assign w_last     = w_tick && (r_remaining == 13'd1);
   assign w_load_sat = (bus.load_sec > c_MAX_SEC) ? c_MAX_SEC : bus.load_sec;

   // Sequencer: state, remaining-seconds counter and gated prescaler
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_remaining <= '0;
         r_presc     <= '0;
      end else if (bus.abort) begin
         // abort beats every other command; remaining time is kept
         r_state <= S_IDLE;
         r_presc <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // a load in the same cycle as start wins; start is dropped
               if (bus.load_en) begin
                  r_remaining <= w_load_sat;
               end else if (bus.start && (r_remaining != 13'd0)) begin
                  r_state <= S_RUN;
                  r_presc <= '0;
               end
            end
            S_RUN: begin
               if (w_tick) begin
                  r_presc     <= '0;
                  r_remaining <= r_remaining - 13'd1;
                  // the final tick takes precedence over a pause request
                  if (w_last) begin
                     r_state <= S_DONE;
                  end else if (bus.pause_tgl) begin
                     r_state <= S_PAUSE;
                  end
               end else begin
                  r_presc <= r_presc + c_PRESC_ONE;
                  if (bus.pause_tgl) begin
                     r_state <= S_PAUSE;
                  end
               end
            end
            S_PAUSE: begin
               // prescaler is held so the partial second survives the pause
               if (bus.pause_tgl) begin
                  r_state <= S_RUN;
               end
            end
            S_DONE: begin
               if (bus.load_en) begin
                  r_remaining <= w_load_sat;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Display registers: MM/SS derived from the binary counter one cycle later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_minutes <= '0;
         r_seconds <= '0;
      end else begin
         r_minutes <= 7'(r_remaining / c_SIXTY);
         r_seconds <= 6'(r_remaining % c_SIXTY);
      end
   end

   assign bus.sec_tick = w_tick;
   assign bus.expired  = w_last;
   assign bus.state    = r_state;
   assign bus.warn     = ((r_state == S_RUN) || (r_state == S_PAUSE)) &&
                         (r_remaining != 13'd0) && (r_remaining <= c_WARN_SEC);
   assign bus.minutes  = r_minutes;
   assign bus.seconds  = r_seconds;

endmodule
`default_nettype wire
